// File: rtl/icache_fill_ctrl.sv
// Instruction-cache line-fill controller: fetches four sequential words for a
// missing line, streams them into the line assembler, then writes the line.
module icache_fill_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  miss,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  asm_clr,
  output logic                  asm_ld,
  output logic [1:0]            asm_offset,
  output logic [31:0]           asm_data,
  output logic                  line_we,
  output logic [ADDR_WIDTH-5:0] line_tag,
  output logic                  stall
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            cnt_r;
  logic [1:0]            cnt_s;
  logic [ADDR_WIDTH-5:0] base_r;
  logic [ADDR_WIDTH-5:0] base_s;
  logic                  rden_s;
  logic                  ld_s;
  logic                  we_s;
  logic                  aclr_s;
  logic                  stall_s;

  // The byte offset within a line never affects the fill.
  logic unused_s;
  assign unused_s = ^miss_addr[3:0];

  // State, word counter and line base registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      base_r  <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      base_r  <= base_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    base_s  = base_r;
    rden_s  = 1'b0;
    ld_s    = 1'b0;
    we_s    = 1'b0;
    aclr_s  = 1'b0;
    stall_s = 1'b1;
    case (state_r)
      IDLE: begin
        stall_s = miss;
        aclr_s  = miss;
        if (miss) begin
          base_s  = miss_addr[ADDR_WIDTH-1:4];
          cnt_s   = 2'd0;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        rden_s  = 1'b1;
        state_s = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          ld_s = 1'b1;
          if (cnt_r == 2'd3) begin
            state_s = WRITE;
          end else begin
            cnt_s   = cnt_r + 2'd1;
            state_s = REQ;
          end
        end else begin
          state_s = WAIT;
        end
      end
      WRITE: begin
        we_s    = 1'b1;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Strobes and passthroughs are held at zero while reset is asserted.
  assign mem_rden   = rden_s  & ~clr;
  assign asm_ld     = ld_s    & ~clr;
  assign line_we    = we_s    & ~clr;
  assign asm_clr    = aclr_s  & ~clr;
  assign stall      = stall_s & ~clr;
  assign mem_addr   = clr ? {ADDR_WIDTH{1'b0}} : {base_r, cnt_r, 2'b00};
  assign asm_offset = clr ? 2'd0 : cnt_r;
  assign asm_data   = clr ? 32'd0 : mem_rdata;
  assign line_tag   = base_r;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: stimulus queues expected memory
// requests, assembler loads and line writes; a negedge monitor checks them.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = 32'd0;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        asm_clr;
  logic        asm_ld;
  logic [1:0]  asm_offset;
  logic [31:0] asm_data;
  logic        line_we;
  logic [27:0] line_tag;
  logic        stall;

  logic        resp_valid = 1'b0;
  logic [31:0] resp_data  = 32'd0;
  logic        spur_valid = 1'b0;

  assign mem_valid = resp_valid | spur_valid;
  assign mem_rdata = resp_valid ? resp_data : 32'h0000_0BAD;

  icache_fill_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .clr(clr), .miss(miss), .miss_addr(miss_addr),
    .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .asm_clr(asm_clr), .asm_ld(asm_ld),
    .asm_offset(asm_offset), .asm_data(asm_data), .line_we(line_we),
    .line_tag(line_tag), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [1:0]  off;
  } exp_t;

  exp_t rd_q[$];
  exp_t ld_q[$];
  exp_t we_q[$];
  int   lat_q[$];
  logic [31:0] dat_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rden) begin
      if (rd_q.size() == 0) chk("unexpected_rden", 32'd1, 32'd0);
      else begin
        e = rd_q.pop_front();
        chk("rden_cycle", cyc, e.cyc);
        chk("rden_addr", mem_addr, e.val);
      end
    end
    if (asm_ld) begin
      if (ld_q.size() == 0) chk("unexpected_asm_ld", 32'd1, 32'd0);
      else begin
        e = ld_q.pop_front();
        chk("ld_cycle", cyc, e.cyc);
        chk("ld_offset", {30'd0, asm_offset}, {30'd0, e.off});
        chk("ld_data", asm_data, e.val);
      end
    end
    if (line_we) begin
      if (we_q.size() == 0) chk("unexpected_line_we", 32'd1, 32'd0);
      else begin
        e = we_q.pop_front();
        chk("we_cycle", cyc, e.cyc);
        chk("we_tag", {4'd0, line_tag}, e.val);
      end
    end
  end

  // Memory responder: answers each request after its queued latency.
  initial begin
    int          w;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_rden && !clr) begin
        w = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        d = (dat_q.size() != 0) ? dat_q.pop_front() : 32'hDEAD_0000;
        tick();
        repeat (w) tick();
        resp_valid = 1'b1;
        resp_data  = d;
        tick();
        resp_valid = 1'b0;
      end
    end
  end

  // Expected events of one complete fill starting with miss accepted at t0.
  function automatic int push_fill(input logic [31:0] addr, input int t0,
                                   input int l0, input int l1, input int l2,
                                   input int l3, input logic [31:0] d0);
    int lat[4];
    int s = 0;
    int r;
    logic [1:0] kk;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      r  = t0 + 1 + 2 * k + s;
      rd_q.push_back('{r, {addr[31:4], kk, 2'b00}, 2'd0});
      ld_q.push_back('{r + 1 + lat[k], d0 + k, kk});
      lat_q.push_back(lat[k]);
      dat_q.push_back(d0 + k);
      s += lat[k];
    end
    we_q.push_back('{t0 + 9 + s, {4'd0, addr[31:4]}, 2'd0});
    return s;
  endfunction

  task automatic do_fill(input logic [31:0] addr, input int l0, input int l1,
                         input int l2, input int l3, input logic [31:0] d0,
                         input bit from_reset, input bit spur);
    int t0;
    int s;
    t0 = cyc;
    s  = push_fill(addr, t0, l0, l1, l2, l3, d0);
    miss_addr = addr;
    miss = 1'b1;
    if (from_reset) clr = 1'b0;
    #1;
    chk("accept_stall", {31'd0, stall}, 32'd1);
    chk("accept_asm_clr", {31'd0, asm_clr}, 32'd1);
    while (cyc < t0 + 10 + s) begin
      tick();
      miss = 1'b0;
      spur_valid = spur && (cyc == t0 + 1 || cyc == t0 + 9 + s || cyc == t0 + 10 + s);
    end
    chk("stall_in_done", {31'd0, stall}, 32'd1);
    tick();
    spur_valid = 1'b0;
    #1;
    chk("stall_low_after_fill", {31'd0, stall}, 32'd0);
    chk("line_tag_held", {4'd0, line_tag}, {4'd0, addr[31:4]});
  endtask

  initial begin
    int t0;
    int s;
    // Reset held with miss high: every output must stay at zero.
    miss = 1'b1;
    miss_addr = 32'h0000_1234;
    repeat (3) tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_asm_clr", {31'd0, asm_clr}, 32'd0);
    chk("rst_mem_rden", {31'd0, mem_rden}, 32'd0);
    chk("rst_asm_ld", {31'd0, asm_ld}, 32'd0);
    chk("rst_line_we", {31'd0, line_we}, 32'd0);
    chk("rst_line_tag", {4'd0, line_tag}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Release reset into a zero-wait fill of 0x1234.
    do_fill(32'h0000_1234, 0, 0, 0, 0, 32'h0000_00A0, 1'b1, 1'b0);
    repeat (2) tick();

    // Spurious return in IDLE, then a variable-latency fill with strays.
    spur_valid = 1'b1;
    #1;
    chk("idle_spur_no_ld", {31'd0, asm_ld}, 32'd0);
    tick();
    spur_valid = 1'b0;
    chk("idle_spur_no_stall", {31'd0, stall}, 32'd0);
    do_fill(32'h0000_8000, 0, 3, 1, 2, 32'h0000_00B0, 1'b0, 1'b1);
    repeat (2) tick();

    // Reset pulsed while waiting for word 2: line must never be written.
    t0 = cyc;
    rd_q.push_back('{t0 + 1, 32'h0000_5000, 2'd0});
    rd_q.push_back('{t0 + 3, 32'h0000_5004, 2'd0});
    rd_q.push_back('{t0 + 5, 32'h0000_5008, 2'd0});
    ld_q.push_back('{t0 + 2, 32'h0000_00D0, 2'd0});
    ld_q.push_back('{t0 + 4, 32'h0000_00D1, 2'd1});
    lat_q.push_back(0); lat_q.push_back(0); lat_q.push_back(4);
    dat_q.push_back(32'h0000_00D0); dat_q.push_back(32'h0000_00D1);
    dat_q.push_back(32'h0000_00D2);
    miss_addr = 32'h0000_5000;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    while (cyc < t0 + 7) tick();
    chk("abort_stall_before", {31'd0, stall}, 32'd1);
    clr = 1'b1;
    #1;
    chk("abort_stall_in_clr", {31'd0, stall}, 32'd0);
    tick();
    clr = 1'b0;
    while (cyc < t0 + 14) tick();
    chk("abort_idle_stall", {31'd0, stall}, 32'd0);
    chk("abort_rd_q_drained", rd_q.size(), 32'd0);
    chk("abort_ld_q_drained", ld_q.size(), 32'd0);
    do_fill(32'h0000_0040, 0, 0, 0, 0, 32'h0000_00C0, 1'b0, 1'b0);
    repeat (2) tick();

    // Miss held through DONE: an immediate second fill of the same line.
    t0 = cyc;
    s = push_fill(32'h0000_2000, t0, 0, 0, 0, 0, 32'h0000_00E0);
    s = push_fill(32'h0000_2000, t0 + 11 + s, 1, 0, 0, 0, 32'h0000_00F0);
    miss_addr = 32'h0000_2000;
    miss = 1'b1;
    while (cyc < t0 + 11) tick();
    chk("refill_asm_clr", {31'd0, asm_clr}, 32'd1);
    chk("refill_stall", {31'd0, stall}, 32'd1);
    tick();
    miss = 1'b0;
    while (cyc < t0 + 22 + s) tick();
    chk("refill_stall_low", {31'd0, stall}, 32'd0);

    repeat (3) tick();
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("ld_q_empty", ld_q.size(), 32'd0);
    chk("we_q_empty", we_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
